axil_master_arbiter: RTL
========================

# axil_master_arbiter

Shares one AXI-Lite master port (the PS-to-PL register bus used by the kria_generic testbenches and the on-PL register sequencers) between N_REQ independent command requesters. Each requester presents single-beat read or write commands on a valid/ready interface; the block picks one with round-robin fairness, runs the full AXI-Lite transaction, and returns read data and status to that requester only. Only one transaction is outstanding at a time.

## Interface
- N_REQ, 2: number of requesters, 2..8.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; wstrb is all-ones, DATA_W/8 bits.
- clk  in  1  sole clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_i  in  N_REQ  command valid, one per requester.
- req_ready_o  out  N_REQ  command accepted; one-hot or zero.
- req_we_i  in  N_REQ  1 = write, 0 = read.
- req_addr_i  in  N_REQ*ADDR_W  packed, requester k at bits [k*ADDR_W +: ADDR_W].
- req_wdata_i  in  N_REQ*DATA_W  packed likewise.
- rsp_valid_o  out  N_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata_o  out  DATA_W  read data; valid with rsp_valid_o; 0 for writes.
- rsp_err_o  out  1  1 if BRESP/RRESP != OKAY; valid with rsp_valid_o.
- busy_o  out  1  high whenever state != IDLE.
- m_axil_aw*/w*/b*/ar*/r*: standard AXI-Lite master channels (awaddr, awprot=0, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arprot=0, arvalid, arready, rdata, rresp, rvalid, rready).

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: grant = first requester with req_valid_i set, scanning from (last_grant+1) mod N_REQ upward with wrap. req_ready_o[grant] = 1 combinationally in IDLE only. On valid&ready edge: latch addr/wdata/we/index, update last_grant = grant, go WR_REQ (we=1) or RD_REQ.
- WR_REQ: awvalid and wvalid both asserted from state entry. Each drops independently after its own handshake; AW and W may complete in either order or the same cycle. When both have completed, go WR_RESP.
- WR_RESP: bready = 1. On bvalid, capture err = (bresp != 2'b00), rdata = 0, go DONE.
- RD_REQ: arvalid = 1 until arready; then RD_RESP.
- RD_RESP: rready = 1. On rvalid, capture rdata, err = (rresp != 2'b00), go DONE.
- DONE: rsp_valid_o[index] = 1 for exactly one cycle, then IDLE.
- Address/data/valid outputs on AXI are registered; valid, once raised, is held until handshake (no AXI valid withdrawal).
- Requester commands not granted remain pending and are not modified or dropped.

## Timing
- Reset (async assert, sync deassert internally): state IDLE, all AXI valids/readies 0, awaddr/araddr/wdata 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0, busy_o 0, last_grant = N_REQ-1 so requester 0 has top priority first.
- Reset mid-transaction: all outputs return to reset values immediately; in-flight AXI transaction is abandoned; no rsp_valid_o issued.
- Zero-wait slave, write: accept edge T0, aw/w handshake T1, bvalid at T2 accepted, rsp_valid_o during T3, next accept possible T4. Read identical timing. Minimum 4 cycles per transaction.
- rsp_rdata_o/rsp_err_o hold their value until next DONE.
- Simultaneous req_valid_i on all lines: grants rotate strictly 0,1,...,N_REQ-1,0.
- Requester raising valid during DONE waits until IDLE; it is not lost.

## Test plan
- Single write req0 addr 0x0000_0010 data 0xDEAD_BEEF, zero-wait slave -> one AW/W with wstrb 0xF, rsp_valid_o = 2'b01 at T3, rsp_err_o 0.
- Single read req1 addr 0x0000_0020, slave returns 0x1234_5678 with RRESP=SLVERR after 5 wait cycles -> rsp_valid_o = 2'b10, rsp_rdata_o 0x1234_5678, rsp_err_o 1.
- Both requesters hold valid continuously for 6 commands each -> grants alternate 0,1,0,1...; each gets exactly 6 rsp pulses, none duplicated.
- Write with wready 3 cycles before awready, then reverse order -> each valid dropped after its own handshake, exactly one AW and one W beat, bready only in WR_RESP.
- bvalid delayed 10 cycles -> busy_o high throughout, req_ready_o all 0, no second AW issued.
- rst_n pulsed low during RD_RESP -> arvalid/rready/rsp_valid_o 0 immediately; after release first grant goes to requester 0.

Source files
------------

// File: rtl/axil_master_arbiter.sv
// axil_master_arbiter: round-robin share of one AXI-Lite master port among N_REQ single-beat requesters
module axil_master_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [N_REQ-1:0]          req_we_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata_i,
  output logic [N_REQ-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      busy_o,
  output logic [ADDR_W-1:0]         m_axil_awaddr,
  output logic [2:0]                m_axil_awprot,
  output logic                      m_axil_awvalid,
  input  logic                      m_axil_awready,
  output logic [DATA_W-1:0]         m_axil_wdata,
  output logic [DATA_W/8-1:0]       m_axil_wstrb,
  output logic                      m_axil_wvalid,
  input  logic                      m_axil_wready,
  input  logic [1:0]                m_axil_bresp,
  input  logic                      m_axil_bvalid,
  output logic                      m_axil_bready,
  output logic [ADDR_W-1:0]         m_axil_araddr,
  output logic [2:0]                m_axil_arprot,
  output logic                      m_axil_arvalid,
  input  logic                      m_axil_arready,
  input  logic [DATA_W-1:0]         m_axil_rdata,
  input  logic [1:0]                m_axil_rresp,
  input  logic                      m_axil_rvalid,
  output logic                      m_axil_rready
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;
  state_t state;
  logic [IW-1:0] last_grant, grant, idx, owner;
  logic found, accept;
  logic [1:0] rst_sync;
  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;
  assign m_axil_wstrb  = '1;
  assign busy_o        = state != IDLE;
  // Deassertion is synchronised by holding off grants until the sync chain fills.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  always_comb begin
    grant = last_grant;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IW'((int'(last_grant) + i) % N_REQ);
      if (!found && req_valid_i[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end
  assign accept      = state == IDLE && found && rst_sync[1];
  assign req_ready_o = accept ? N_REQ'(1) << grant : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= IW'(N_REQ - 1);
      owner          <= '0;
      m_axil_awaddr  <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_araddr  <= '0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      rsp_valid_o    <= '0;
      rsp_rdata_o    <= '0;
      rsp_err_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          owner      <= grant;
          last_grant <= grant;
          if (req_we_i[grant]) begin
            m_axil_awaddr  <= req_addr_i[int'(grant)*ADDR_W +: ADDR_W];
            m_axil_wdata   <= req_wdata_i[int'(grant)*DATA_W +: DATA_W];
            m_axil_awvalid <= 1'b1;
            m_axil_wvalid  <= 1'b1;
            state          <= WR_REQ;
          end else begin
            m_axil_araddr  <= req_addr_i[int'(grant)*ADDR_W +: ADDR_W];
            m_axil_arvalid <= 1'b1;
            state          <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wready) m_axil_wvalid <= 1'b0;
          if ((!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready)) begin
            m_axil_bready <= 1'b1;
            state         <= WR_RESP;
          end
        end
        WR_RESP: if (m_axil_bvalid) begin
          m_axil_bready <= 1'b0;
          rsp_rdata_o   <= '0;
          rsp_err_o     <= |m_axil_bresp;
          rsp_valid_o   <= N_REQ'(1) << owner;
          state         <= DONE;
        end
        RD_REQ: if (m_axil_arready) begin
          m_axil_arvalid <= 1'b0;
          m_axil_rready  <= 1'b1;
          state          <= RD_RESP;
        end
        RD_RESP: if (m_axil_rvalid) begin
          m_axil_rready <= 1'b0;
          rsp_rdata_o   <= m_axil_rdata;
          rsp_err_o     <= |m_axil_rresp;
          rsp_valid_o   <= N_REQ'(1) << owner;
          state         <= DONE;
        end
        DONE: begin
          rsp_valid_o <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
